// File: rtl/ws2811_frame_tx.sv
// ws2811_frame_tx: serialises NUM_LEDS 24-bit LED words onto a WS2811 data
// line. LED 0 goes out first, and each word goes out MSB first. Each bit lasts
// TBIT cycles. The line is high for T1H cycles (a 1) or T0H cycles (a 0) at the
// start of the bit. A low latch gap follows the last bit.
//
// Timing from the accepting edge E0:
//   bit n starts at E0 + TBIT*n
//   GAP holds the line low from E0 + TBIT*NBITS
//   FIM is the final cycle of the latch gap
//   pronto is high (ocupado low) in the cycle after E0 + TBIT*NBITS + TRESET
// That single-cycle pronto coincides with the return to OCIOSO. A held iniciar
// therefore restarts one edge after the pronto pulse. The line stays low for at
// least TRESET cycles before every pronto.
// TRESET must be at least 2.
module ws2811_frame_tx #(
    parameter int NUM_LEDS = 11,
    parameter int T0H      = 13,
    parameter int T1H      = 30,
    parameter int TBIT     = 63,
    parameter int TRESET   = 2800
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [24*NUM_LEDS-1:0]  frame,
    output logic                    serial,
    output logic                    db_serial,
    output logic                    ocupado,
    output logic                    pronto
);

    localparam int NBITS = 24 * NUM_LEDS;
    localparam int CW    = (TBIT > 1)   ? $clog2(TBIT)       : 1;
    localparam int BW    = (NBITS > 1)  ? $clog2(NBITS)      : 1;
    localparam int GW    = (TRESET > 2) ? $clog2(TRESET - 1) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TRESET - 2);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BIT    = 2'd1,
        GAP    = 2'd2,
        FIM    = 2'd3
    } state_t;

    state_t             state_r,  state_next_s;
    logic [CW-1:0]      cyc_cnt_r, cyc_next_s;
    logic [BW-1:0]      bit_cnt_r, bit_next_s;
    logic [GW-1:0]      gap_cnt_r, gap_next_s;
    logic [NBITS-1:0]   shreg_r,  shreg_next_s;
    logic [NBITS-1:0]   frame_ord_s;
    logic [NBITS-1:0]   shreg_sh_s;
    logic [CW-1:0]      cyc_inc_s;
    logic               serial_r, serial_next_s;
    logic               ocupado_r, ocupado_next_s;
    logic               pronto_r, pronto_next_s;

    // Number of high cycles for a bit of the given value.
    function automatic logic [CW-1:0] high_time(input logic b);
        if (b) begin
            return T1H_C;
        end else begin
            return T0H_C;
        end
    endfunction

    // Reverse LED order so that LED 0 sits in the top word and shifts out first.
    always_comb begin
        frame_ord_s = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            frame_ord_s[(NUM_LEDS-1-k)*24 +: 24] = frame[k*24 +: 24];
        end
    end

    assign shreg_sh_s = {shreg_r[NBITS-2:0], 1'b0};
    assign cyc_inc_s  = cyc_cnt_r + CW'(1);

    // Next-state, counter, shift register and output logic.
    always_comb begin
        state_next_s   = state_r;
        cyc_next_s     = cyc_cnt_r;
        bit_next_s     = bit_cnt_r;
        gap_next_s     = gap_cnt_r;
        shreg_next_s   = shreg_r;
        serial_next_s  = 1'b0;
        ocupado_next_s = 1'b0;
        pronto_next_s  = 1'b0;
        case (state_r)
            OCIOSO: begin
                if (iniciar) begin
                    state_next_s   = BIT;
                    shreg_next_s   = frame_ord_s;
                    cyc_next_s     = '0;
                    bit_next_s     = '0;
                    gap_next_s     = '0;
                    serial_next_s  = (high_time(frame_ord_s[NBITS-1]) != '0);
                    ocupado_next_s = 1'b1;
                end else begin
                    state_next_s   = OCIOSO;
                end
            end
            BIT: begin
                ocupado_next_s = 1'b1;
                if (cyc_cnt_r == CYC_LAST) begin
                    cyc_next_s = '0;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_next_s  = GAP;
                        gap_next_s    = '0;
                        serial_next_s = 1'b0;
                    end else begin
                        bit_next_s    = bit_cnt_r + BW'(1);
                        shreg_next_s  = shreg_sh_s;
                        serial_next_s = (high_time(shreg_sh_s[NBITS-1]) != '0);
                    end
                end else begin
                    cyc_next_s    = cyc_inc_s;
                    serial_next_s = (cyc_inc_s < high_time(shreg_r[NBITS-1]));
                end
            end
            GAP: begin
                ocupado_next_s = 1'b1;
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = FIM;
                end else begin
                    gap_next_s = gap_cnt_r + GW'(1);
                end
            end
            FIM: begin
                state_next_s  = OCIOSO;
                pronto_next_s = 1'b1;
            end
            default: begin
                state_next_s = OCIOSO;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= OCIOSO;
            cyc_cnt_r <= '0;
            bit_cnt_r <= '0;
            gap_cnt_r <= '0;
            shreg_r   <= '0;
            serial_r  <= 1'b0;
            ocupado_r <= 1'b0;
            pronto_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cyc_cnt_r <= cyc_next_s;
            bit_cnt_r <= bit_next_s;
            gap_cnt_r <= gap_next_s;
            shreg_r   <= shreg_next_s;
            serial_r  <= serial_next_s;
            ocupado_r <= ocupado_next_s;
            pronto_r  <= pronto_next_s;
        end
    end

    assign serial    = serial_r;
    assign db_serial = serial_r;
    assign ocupado   = ocupado_r;
    assign pronto    = pronto_r;

endmodule

// File: tb/tb_ws2811_frame_tx.sv
// Directed bench for ws2811_frame_tx, using a 4-LED frame to keep runs short.
// Serial, ocupado and pronto are compared cycle by cycle against a waveform
// model built from the bit timing parameters.
module tb_ws2811_frame_tx;

    localparam int NL     = 4;
    localparam int FW     = 24 * NL;
    localparam int NBITS  = 24 * NL;
    localparam int T0H    = 13;
    localparam int T1H    = 30;
    localparam int TBIT   = 63;
    localparam int TRESET = 2800;
    localparam int BIT_CYC   = NBITS * TBIT;        // 6048
    localparam int FRAME_CYC = BIT_CYC + TRESET;    // pronto cycle index: 8848
    localparam int PERIOD    = FRAME_CYC + 1;       // back-to-back spacing

    logic          clock;
    logic          reset;
    logic          iniciar;
    logic [FW-1:0] frame;
    logic          serial;
    logic          db_serial;
    logic          ocupado;
    logic          pronto;

    int n_checks;
    int n_errors;

    ws2811_frame_tx #(
        .NUM_LEDS (NL),
        .T0H      (T0H),
        .T1H      (T1H),
        .TBIT     (TBIT),
        .TRESET   (TRESET)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .frame     (frame),
        .serial    (serial),
        .db_serial (db_serial),
        .ocupado   (ocupado),
        .pronto    (pronto)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected serial level k cycles after the accepting edge.
    function automatic logic exp_serial(input logic [FW-1:0] fr, input int k);
        int   n;
        int   c;
        int   led;
        int   b;
        logic v;
        if (k >= BIT_CYC) return 1'b0;
        n   = k / TBIT;
        c   = k % TBIT;
        led = n / 24;
        b   = 23 - (n % 24);
        v   = fr[led*24 + b];
        return (c < (v ? T1H : T0H));
    endfunction

    // Sample cycles 0..ncyc-1 after an accepting edge, for nframes back-to-back frames.
    task automatic watch(input logic [FW-1:0] fr, input int ncyc, input int nframes,
                         output int wave_err, output int busy_err,
                         output int pron_err, output int np);
        int   f;
        int   kl;
        logic es;
        logic eo;
        logic ep;
        wave_err = 0;
        busy_err = 0;
        pron_err = 0;
        np       = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            f  = k / PERIOD;
            kl = k % PERIOD;
            if (f < nframes) begin
                es = exp_serial(fr, kl);
                eo = (kl < FRAME_CYC);
                ep = (kl == FRAME_CYC);
            end else begin
                es = 1'b0;
                eo = 1'b0;
                ep = 1'b0;
            end
            if (serial !== es || db_serial !== es) wave_err++;
            if (ocupado !== eo) busy_err++;
            if (pronto !== ep) pron_err++;
            if (pronto === 1'b1) np++;
        end
    endtask

    initial begin
        logic [FW-1:0] fr;
        int we;
        int be;
        int pe;
        int np;
        int highs;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        iniciar  = 1'b0;
        frame    = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_serial",    32'(serial),    32'd0);
        check_eq("rst_db_serial", 32'(db_serial), 32'd0);
        check_eq("rst_ocupado",   32'(ocupado),   32'd0);
        check_eq("rst_pronto",    32'(pronto),    32'd0);
        reset = 1'b0;
        @(negedge clock);

        // LED 0 = FF0000: first 8 bits long, rest short, one pronto at FRAME_CYC.
        fr          = '0;
        fr[23:0]    = 24'hFF0000;
        frame       = fr;
        iniciar     = 1'b1;
        @(posedge clock);
        fork
            watch(fr, FRAME_CYC + 4, 1, we, be, pe, np);
            begin
                @(negedge clock);
                iniciar = 1'b0;
            end
        join
        check_eq("t1_wave",   32'(we), 32'd0);
        check_eq("t1_busy",   32'(be), 32'd0);
        check_eq("t1_pronto", 32'(pe), 32'd0);
        check_eq("t1_npulse", 32'(np), 32'd1);

        // Last LED = 000001, plus ignored iniciar and all-ones frame at bit 50.
        fr          = '0;
        fr[FW-24 +: 24] = 24'h000001;
        frame       = fr;
        @(negedge clock);
        iniciar     = 1'b1;
        @(posedge clock);
        fork
            watch(fr, FRAME_CYC + 4, 1, we, be, pe, np);
            begin
                @(negedge clock);
                iniciar = 1'b0;
                repeat (50 * TBIT - 1) @(negedge clock);
                iniciar = 1'b1;
                frame   = '1;
                @(negedge clock);
                iniciar = 1'b0;
            end
        join
        check_eq("t2_wave",   32'(we), 32'd0);
        check_eq("t2_busy",   32'(be), 32'd0);
        check_eq("t2_pronto", 32'(pe), 32'd0);
        check_eq("t2_npulse", 32'(np), 32'd1);

        // Reset for one cycle in the middle of bit 50 aborts the frame.
        fr       = '0;
        fr[47:24] = 24'hFFFFFF;
        frame    = fr;
        @(negedge clock);
        iniciar  = 1'b1;
        @(negedge clock);
        iniciar  = 1'b0;
        repeat (50 * TBIT + 4) @(negedge clock);
        reset    = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        check_eq("t3_serial",  32'(serial),  32'd0);
        check_eq("t3_ocupado", 32'(ocupado), 32'd0);
        check_eq("t3_pronto",  32'(pronto),  32'd0);
        np    = 0;
        highs = 0;
        for (int k = 0; k < FRAME_CYC + 4; k++) begin
            @(negedge clock);
            if (pronto === 1'b1) np++;
            if (serial !== 1'b0 || ocupado !== 1'b0) highs++;
        end
        check_eq("t3_no_pronto", 32'(np),    32'd0);
        check_eq("t3_idle",      32'(highs), 32'd0);

        // iniciar held across three frames: three full frames, prontos PERIOD apart.
        fr          = '0;
        fr[47:24]   = 24'hA53C81;
        fr[71:48]   = 24'h800000;
        frame       = fr;
        @(negedge clock);
        iniciar     = 1'b1;
        @(posedge clock);
        fork
            watch(fr, 3 * PERIOD + 8, 3, we, be, pe, np);
            begin
                repeat (2 * PERIOD + 100) @(negedge clock);
                iniciar = 1'b0;
            end
        join
        check_eq("t4_wave",   32'(we), 32'd0);
        check_eq("t4_busy",   32'(be), 32'd0);
        check_eq("t4_pronto", 32'(pe), 32'd0);
        check_eq("t4_npulse", 32'(np), 32'd3);

        // iniciar and reset together: reset wins, module stays idle.
        @(negedge clock);
        iniciar = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        reset   = 1'b0;
        check_eq("t5_serial",  32'(serial),  32'd0);
        check_eq("t5_ocupado", 32'(ocupado), 32'd0);
        repeat (5) @(negedge clock);
        check_eq("t5_serial_later",  32'(serial),  32'd0);
        check_eq("t5_ocupado_later", 32'(ocupado), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
